// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module   : imem_loader_pkg
// Brief    : Shared types and constants for the instruction-memory boot loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    localparam int          IMEM_WORDS           = 256;
    localparam logic [31:0] IMEM_SUPERVISOR_MASK = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_t;

    function automatic logic state_accepts_byte(input loader_state_t s);
        return (s == ST_IDLE) || (s == ST_LOAD) || (s == ST_CHECK);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
// ============================================================================
// Module   : word_assembler
// Brief    : Big-endian byte-to-word shifter with byte counter and XOR checksum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic [7:0]  o_csum,
    output logic        o_word_full
);

    logic [31:0] r_word;
    logic [1:0]  r_cnt;
    logic [7:0]  r_csum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= 32'd0;
            r_cnt  <= 2'd0;
            r_csum <= 8'd0;
        end else if (i_clear) begin
            r_cnt  <= 2'd0;
            r_csum <= 8'd0;
        end else if (i_shift) begin
            r_word <= {r_word[23:0], i_byte};
            r_csum <= r_csum ^ i_byte;
            r_cnt  <= r_cnt + 2'd1;
        end
    end

    // Strobe coincides with the transfer of the 4th byte of a word.
    assign o_word_full = i_shift && (r_cnt == 2'd3);
    assign o_word      = r_word;
    assign o_csum      = r_csum;

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Brief    : Boot-time byte-stream loader for the instruction memory; holds the
//            CPU in reset until the image is written and its checksum matches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_WORDS = imem_loader_pkg::IMEM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_wa,
    output logic [31:0] imem_wd,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam int c_IDX_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

    loader_state_t        r_state;
    loader_state_t        w_next;
    logic                 r_ready;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   r_last;

    logic                 w_xfer;
    logic                 w_clear;
    logic                 w_shift;
    logic [31:0]          w_word;
    logic [7:0]           w_csum;
    logic                 w_word_full;
    logic [31:0]          w_wa_raw;

    assign w_xfer  = byte_valid && r_ready;
    assign w_shift = (r_state == ST_LOAD) && w_xfer;
    assign w_clear = ((r_state == ST_IDLE) && w_xfer) ||
                     (((r_state == ST_DONE) || (r_state == ST_ERROR)) && start);

    word_assembler u_word_assembler (
        .clk         (clk),
        .rst         (reset),
        .i_clear     (w_clear),
        .i_shift     (w_shift),
        .i_byte      (byte_data),
        .o_word      (w_word),
        .o_csum      (w_csum),
        .o_word_full (w_word_full)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_xfer) w_next = ST_LOAD;
            ST_LOAD:  if (w_word_full) w_next = ST_WRITE;
            ST_WRITE: w_next = (r_idx == r_last) ? ST_CHECK : ST_LOAD;
            ST_CHECK: if (w_xfer) w_next = (byte_data == w_csum) ? ST_DONE : ST_ERROR;
            ST_DONE:  if (start) w_next = ST_IDLE;
            ST_ERROR: if (start) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Ready is registered from the next state so it stays low through reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_idx   <= '0;
            r_last  <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= state_accepts_byte(w_next);
            if ((r_state == ST_IDLE) && w_xfer) begin
                r_last <= byte_data[c_IDX_W-1:0];
                r_idx  <= '0;
            end else if ((r_state == ST_WRITE) && (r_idx != r_last)) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign w_wa_raw   = {{(30 - c_IDX_W){1'b0}}, r_idx, 2'b00};
    assign imem_wa    = w_wa_raw & IMEM_SUPERVISOR_MASK;
    assign imem_wd    = w_word;
    assign imem_we    = (r_state == ST_WRITE);
    assign byte_ready = r_ready;
    assign done       = (r_state == ST_DONE);
    assign err        = (r_state == ST_ERROR);
    assign cpu_hold   = (r_state != ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed self-checking bench for the instruction-memory loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_wa;
    logic [31:0] imem_wd;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int          total;
    int          bad;
    int          stall_max;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          low_ready_cnt;
    logic        bit31_seen;
    logic        we_ready_clash;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_wa    (imem_wa),
        .imem_wd    (imem_wd),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            wq_addr.push_back(imem_wa);
            wq_data.push_back(imem_wd);
            if (byte_ready) we_ready_clash = 1'b1;
        end
        if (imem_wa[31]) bit31_seen = 1'b1;
        if (!reset && !byte_ready && !done && !err) low_ready_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        low_ready_cnt  = 0;
        we_ready_clash = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waitc;
        if (stall_max > 0) begin
            int idle;
            idle = $urandom_range(0, stall_max);
            repeat (idle) @(negedge clk);
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        waitc = 0;
        while (!byte_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 50) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic send_words(input logic [7:0] hdr, input logic [31:0] w[$], input logic [7:0] cs);
        send_byte(hdr);
        foreach (w[i]) begin
            send_byte(w[i][31:24]);
            send_byte(w[i][23:16]);
            send_byte(w[i][15:8]);
            send_byte(w[i][7:0]);
        end
        send_byte(cs);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] words[$];
    logic [31:0] ref_addr[$];
    logic [31:0] ref_data[$];
    logic [7:0]  cs;

    initial begin
        total = 0; bad = 0; stall_max = 0;
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        bit31_seen = 1'b0;
        clear_mon();

        // Reset values
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_wa", imem_wa, 32'd0);
        chk("rst_wd", imem_wd, 32'd0);
        chk("rst_flags", {29'd0, cpu_hold, done, err}, 32'h4);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'd0, byte_ready}, 32'd1);

        // 1: single word
        clear_mon();
        words = '{32'h2008_0005};
        send_words(8'h00, words, 8'h2D);
        chk("t1_nwr", wq_addr.size(), 32'd1);
        if (wq_addr.size() == 1) begin
            chk("t1_wa", wq_addr[0], 32'h0);
            chk("t1_wd", wq_data[0], 32'h2008_0005);
        end
        chk("t1_flags", {29'd0, cpu_hold, done, err}, 32'h2);

        // 2: three words back-to-back
        pulse_start();
        chk("restart_flags", {29'd0, cpu_hold, done, err}, 32'h4);
        clear_mon();
        words = '{32'h2008_0005, 32'h2109_0001, 32'hAC09_0004};
        send_words(8'h02, words, 8'hA5);
        chk("t2_nwr", wq_addr.size(), 32'd3);
        if (wq_addr.size() == 3) begin
            chk("t2_wa0", wq_addr[0], 32'h0);
            chk("t2_wa1", wq_addr[1], 32'h4);
            chk("t2_wa2", wq_addr[2], 32'h8);
            chk("t2_wd1", wq_data[1], 32'h2109_0001);
            chk("t2_wd2", wq_data[2], 32'hAC09_0004);
        end
        chk("t2_lowready", low_ready_cnt, 32'd3);
        chk("t2_we_ready", {31'd0, we_ready_clash}, 32'd0);
        chk("t2_done", {31'd0, done}, 32'd1);

        // 3: bad checksum, then recovery
        pulse_start();
        clear_mon();
        words = '{32'h2008_0005};
        send_words(8'h00, words, 8'h2C);
        chk("t3_nwr", wq_addr.size(), 32'd1);
        chk("t3_flags", {29'd0, cpu_hold, done, err}, 32'h5);
        chk("t3_err_ready", {31'd0, byte_ready}, 32'd0);
        pulse_start();
        chk("t3_idle", {29'd0, cpu_hold, done, err}, 32'h4);
        chk("t3_idle_ready", {31'd0, byte_ready}, 32'd1);
        send_words(8'h00, words, 8'h2D);
        chk("t3_recover", {29'd0, cpu_hold, done, err}, 32'h2);

        // 4: stalled 2-word load must match the expected write sequence
        pulse_start();
        clear_mon();
        words = '{32'h2008_0005, 32'h2109_0001};
        stall_max = 3;
        send_words(8'h01, words, 8'h04);
        stall_max = 0;
        ref_addr = '{32'h0, 32'h4};
        ref_data = '{32'h2008_0005, 32'h2109_0001};
        chk("t4_nwr", wq_addr.size(), 32'd2);
        if (wq_addr.size() == 2) begin
            foreach (ref_addr[i]) begin
                chk("t4_wa", wq_addr[i], ref_addr[i]);
                chk("t4_wd", wq_data[i], ref_data[i]);
            end
        end
        chk("t4_done", {31'd0, done}, 32'd1);

        // 5: maximum length image
        pulse_start();
        clear_mon();
        bit31_seen = 1'b0;
        words.delete();
        cs = 8'h00;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] k;
            k = i[7:0];
            words.push_back({k, ~k, 8'h5A, k ^ 8'h3C});
            cs = cs ^ k ^ ~k ^ 8'h5A ^ (k ^ 8'h3C);
        end
        send_words(8'hFF, words, cs);
        chk("t5_nwr", wq_addr.size(), 32'd256);
        if (wq_addr.size() == 256) begin
            chk("t5_wa_mid", wq_addr[100], 32'd400);
            chk("t5_wa_last", wq_addr[255], 32'h3FC);
            chk("t5_wd_last", wq_data[255], 32'hFF00_5AC3);
        end
        chk("t5_bit31", {31'd0, bit31_seen}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd1);

        // 6: reset after 6 data bytes
        pulse_start();
        clear_mon();
        send_byte(8'h01);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h21); send_byte(8'h09);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_we", {31'd0, imem_we}, 32'd0);
        chk("t6_rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("t6_rst_flags", {29'd0, cpu_hold, done, err}, 32'h4);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_idle_ready", {31'd0, byte_ready}, 32'd1);
        clear_mon();
        words = '{32'hAC09_0004};
        send_words(8'h00, words, 8'hA1);
        chk("t6_nwr", wq_addr.size(), 32'd1);
        if (wq_addr.size() == 1) begin
            chk("t6_wa", wq_addr[0], 32'h0);
            chk("t6_wd", wq_data[0], 32'hAC09_0004);
        end
        chk("t6_done", {31'd0, done}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
